i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_tx_if.sv | 14 +
 rtl/i2s_edge_det.sv | 23 ++
 rtl/i2s_tx.sv | 118 +++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared state encoding and default sizes for the I2S transmitter
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int DEFAULT_WS_PERIOD    = 64;

endpackage

// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - stereo sample handshake between a producer and i2s_tx
interface i2s_tx_if import i2s_pkg::*; #(
  parameter int sample_width = DEFAULT_SAMPLE_WIDTH
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [sample_width-1:0] in_left;
  logic [sample_width-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/i2s_edge_det.sv
// rtl/i2s_edge_det.sv - 1-bit registered rise/fall detector; en gates both sampling and pulses
module i2s_edge_det import i2s_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

  assign rise = en & ~q & d;
  assign fall = en & q & ~d;

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S serial transmitter with one-pair holding buffer
// Optional sticky underflow flag enabled by defining I2S_TX_UNDERFLOW_EN.
module i2s_tx import i2s_pkg::*; #(
  parameter int sample_width       = DEFAULT_SAMPLE_WIDTH,
  parameter int word_select_period = DEFAULT_WS_PERIOD
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    bclk,
  input  logic    lrclk,
  i2s_tx_if.slave in_if,
  output logic    sdata,
  output logic    underflow,
  input  logic    underflow_clr
);

  localparam int cnt_w = $clog2(word_select_period);
  localparam logic [cnt_w-1:0] cnt_max   = '1;
  localparam logic [cnt_w-1:0] word_bits = cnt_w'(sample_width);

  i2s_state_e              state_q, state_d;
  logic                    bclk_fall, lr_rise, lr_fall;
  logic                    enter_left, xfer, buf_full;
  logic [2:0]              unused_edge;
  logic [sample_width-1:0] buf_l, buf_r, left_sh, right_sh;
  logic [cnt_w-1:0]        bit_cnt;

  i2s_edge_det u_bclk_det (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(bclk),
    .q(unused_edge[0]), .rise(unused_edge[1]), .fall(bclk_fall)
  );

  // lrclk is only sampled on bclk falls, so a change between falls waits for the next one
  i2s_edge_det u_lr_det (
    .clk(clk), .rst_n(rst_n), .en(bclk_fall), .d(lrclk),
    .q(unused_edge[2]), .rise(lr_rise), .fall(lr_fall)
  );

  assign in_if.in_ready = ~buf_full;
  assign xfer           = in_if.in_valid & ~buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    enter_left = 1'b0;
    if (bclk_fall) begin
      case (state_q)
        SYNC, RIGHT: if (lr_fall) begin
          state_d    = LEFT;
          enter_left = 1'b1;
        end
        LEFT:        if (lr_rise) state_d = RIGHT;
        default:     state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
      left_sh  <= '0;
      right_sh <= '0;
      bit_cnt  <= '0;
      sdata    <= 1'b0;
    end else begin
      // xfer needs an empty buffer, so it never collides with a real unload
      if (xfer) begin
        buf_full <= 1'b1;
        buf_l    <= in_if.in_left;
        buf_r    <= in_if.in_right;
      end else if (enter_left) begin
        buf_full <= 1'b0;
      end
      if (bclk_fall) begin
        if (state_q == SYNC) begin
          sdata <= 1'b0;
        end else begin
          sdata <= (bit_cnt < word_bits) &&
                   ((state_q == LEFT) ? left_sh[sample_width-1] : right_sh[sample_width-1]);
          if (state_q == LEFT) left_sh <= left_sh << 1;
          else                 right_sh <= right_sh << 1;
          if (bit_cnt != cnt_max) bit_cnt <= bit_cnt + cnt_w'(1);
        end
        if (state_d != state_q) bit_cnt <= '0;
        if (enter_left) begin
          left_sh  <= buf_full ? buf_l : '0;
          right_sh <= buf_full ? buf_r : '0;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (enter_left && !buf_full) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = underflow_clr;
  assign underflow  = 1'b0;
`endif

endmodule
